// File: rtl/timer_disp_pkg.sv
// Shared definitions for the timer display path: conversion FSM states,
// active-low seven-segment patterns {g,f,e,d,c,b,a} and the digit lookup.
package timer_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Non-decimal nibbles never reach the display; a dash makes them obvious.
   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. A new conversion starts
// whenever count differs from the last captured value; changes during a
// conversion are picked up on the next IDLE cycle.
//
// Handshake: busy rises the edge count is captured and falls the edge the
// tens/ones/ovf registers are written; those outputs are stable while busy=0.
module bin2bcd_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] count,
   output logic       busy,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       ovf
);
   import timer_disp_pkg::*;

   conv_state_t state, state_nxt;
   logic [7:0]  last;
   logic [7:0]  bin_sr;
   logic [9:0]  bcd;      // {hundreds[1:0], tens[3:0], ones[3:0]}
   logic [9:0]  bcd_adj;
   logic [3:0]  iter;
   logic        load, step, commit;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: eight shift iterations, then one commit cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != last) state_nxt = SHIFT;
         SHIFT:   if (iter == 4'd7)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath strobes decoded from the current state.
   always_comb begin
      load   = (state == IDLE) && (count != last);
      step   = (state == SHIFT);
      commit = (state == DONE);
   end

   // Add-3 correction on tens and ones; hundreds never exceeds 2 so needs none.
   always_comb begin
      bcd_adj = bcd;
      if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
      if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
   end

   // Conversion datapath and registered results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last   <= 8'd0;
         bin_sr <= 8'd0;
         bcd    <= 10'd0;
         iter   <= 4'd0;
         busy   <= 1'b0;
         tens   <= 4'd0;
         ones   <= 4'd0;
         ovf    <= 1'b0;
      end else begin
         if (load) begin
            last   <= count;
            bin_sr <= count;
            bcd    <= 10'd0;
            iter   <= 4'd0;
            busy   <= 1'b1;
         end
         if (step) begin
            {bcd, bin_sr} <= {bcd_adj[8:0], bin_sr, 1'b0};
            iter          <= iter + 4'd1;
         end
         if (commit) begin
            tens <= bcd[7:4];
            ones <= bcd[3:0];
            ovf  <= (bcd[9:8] != 2'd0) || (bcd[7:4] > 4'd9);
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_mux_99.sv
// Two-digit multiplexed common-anode display driver for the 0..99 timer.
// Converts count to BCD and scans tens/ones onto one segment bus, each digit
// lit for REFRESH_DIV cycles. Values above 99 show "--".
// Build option: SEG7_BLANK_LEADING_ZERO_EN blanks a zero tens digit.
module seg7_mux_99 #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] count,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       busy
);
   import timer_disp_pkg::*;

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   logic [3:0]    tens, ones;
   logic          ovf;
   logic [PW-1:0] presc;
   logic          sel, sel_nxt, wrap;
   logic [6:0]    tens_seg, ones_seg, seg_nxt;
   logic [1:0]    an_nxt;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .reset (reset),
      .count (count),
      .busy  (busy),
      .tens  (tens),
      .ones  (ones),
      .ovf   (ovf)
   );

   // Refresh prescaler; the wrap cycle advances the scan.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    presc <= '0;
      else if (wrap) presc <= '0;
      else           presc <= presc + 1'b1;
   end

   // Digit patterns, with dash on overflow and optional leading-zero blank.
   always_comb begin
      ones_seg = ovf ? SEG_DASH : digit_to_seg(ones);
      tens_seg = ovf ? SEG_DASH : digit_to_seg(tens);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
      if (!ovf && (tens == 4'd0)) tens_seg = SEG_BLANK;
`endif
   end

   // Next select, anode and segment values; seg follows the next select so
   // the anode and its pattern switch on the same edge.
   always_comb begin
      wrap    = (presc == PRESC_MAX);
      sel_nxt = wrap ? ~sel : sel;
      an_nxt  = ~(2'b01 << sel_nxt);
      seg_nxt = sel_nxt ? tens_seg : ones_seg;
   end

   // Scan select and registered display outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel <= 1'b0;
         an  <= 2'b10;
         seg <= SEG_0;
      end else begin
         sel <= sel_nxt;
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_mux_99.sv
// Bench for seg7_mux_99 with a short refresh period. Honours
// SEG7_BLANK_LEADING_ZERO_EN when the bench is built with it defined.
module tb_seg7_mux_99;

   localparam int DIV = 4;

`ifdef SEG7_BLANK_LEADING_ZERO_EN
   localparam logic [6:0] SEGT_ZERO = 7'b1111111;
`else
   localparam logic [6:0] SEGT_ZERO = 7'b1000000;
`endif
   localparam logic [6:0] DASH = 7'b0111111;

   logic       clk;
   logic       reset;
   logic [7:0] count;
   logic [6:0] seg;
   logic [1:0] an;
   logic       busy;

   int total = 0;
   int bad   = 0;

   logic [6:0]  seg_tab [10];
   logic [13:0] exp_q [$];
   logic [7:0]  last_v;

   typedef struct {
      logic [7:0] cnt;
      logic [6:0] t;
      logic [6:0] o;
   } vec_t;
   vec_t vecs [11];

   seg7_mux_99 #(.REFRESH_DIV(DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .count (count),
      .seg   (seg),
      .an    (an),
      .busy  (busy)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: decimal digits by plain arithmetic.
   function automatic logic [6:0] model_tens(input int v);
      if (v > 99) return DASH;
      if (v / 10 == 0) return SEGT_ZERO;
      return seg_tab[v / 10];
   endfunction

   function automatic logic [6:0] model_ones(input int v);
      if (v > 99) return DASH;
      return seg_tab[v % 10];
   endfunction

   // Counts negedges with busy high, starting at the current negedge.
   task automatic wait_conv(input int exp_hi, input string name);
      int hi = 0;
      while (busy && hi < 40) begin
         hi++;
         @(negedge clk);
      end
      chk(name, hi, exp_hi);
   endtask

   // Samples 2*DIV cycles against the front of the expected queue.
   task automatic check_window(input string name);
      logic [13:0] e;
      int n_t = 0;
      int n_o = 0;
      if (exp_q.size() == 0) begin
         chk({name, "_queue"}, 0, 1);
         return;
      end
      e = exp_q.pop_front();
      for (int i = 0; i < 2 * DIV; i++) begin
         if (an == 2'b10) begin
            n_o++;
            chk({name, "_ones"}, seg, e[6:0]);
         end else if (an == 2'b01) begin
            n_t++;
            chk({name, "_tens"}, seg, e[13:7]);
         end else begin
            chk({name, "_an"}, an, 2'b10);
         end
         @(negedge clk);
      end
      chk({name, "_ones_time"}, n_o, DIV);
      chk({name, "_tens_time"}, n_t, DIV);
   endtask

   // Full conversion: drive at a negedge, expect 9 busy samples, check display.
   task automatic convert(input logic [7:0] v, input logic [6:0] t, input logic [6:0] o,
                          input string name);
      count = v;
      exp_q.push_back({t, o});
      @(negedge clk);
      wait_conv(9, {name, "_busy"});
      @(negedge clk);
      check_window(name);
      last_v = v;
   endtask

   initial begin
      int v;
      int prev_chg, n_chg;
      logic [1:0] prev_an;
      logic saw_busy;

      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;

      vecs[0]  = '{8'd57,  7'b0010010, 7'b1111000};
      vecs[1]  = '{8'd99,  7'b0010000, 7'b0010000};
      vecs[2]  = '{8'd0,   SEGT_ZERO,  7'b1000000};
      vecs[3]  = '{8'd150, DASH,       DASH};
      vecs[4]  = '{8'd42,  7'b0011001, 7'b0100100};
      vecs[5]  = '{8'd100, DASH,       DASH};
      vecs[6]  = '{8'd10,  7'b1111001, 7'b1000000};
      vecs[7]  = '{8'd9,   SEGT_ZERO,  7'b0010000};
      vecs[8]  = '{8'd255, DASH,       DASH};
      vecs[9]  = '{8'd38,  7'b0110000, 7'b0000000};
      vecs[10] = '{8'd61,  7'b0000010, 7'b1111001};

      // Reset with count=0.
      reset = 1'b0;
      count = 8'd0;
      last_v = 8'd0;
      repeat (3) @(negedge clk);
      chk("reset_an", an, 2'b10);
      chk("reset_seg", seg, 7'b1000000);
      chk("reset_busy", busy, 1'b0);
      reset = 1'b1;

      // Scan period after release; busy must stay low.
      prev_an = an;
      prev_chg = 0;
      n_chg = 0;
      saw_busy = 1'b0;
      for (int c = 1; c <= 6 * DIV; c++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
         if (an != prev_an) begin
            chk("scan_period", c - prev_chg, DIV);
            prev_chg = c;
            n_chg++;
         end
         prev_an = an;
      end
      chk("scan_toggles", n_chg, 6);
      chk("idle_no_busy", saw_busy, 1'b0);
      exp_q.push_back({SEGT_ZERO, seg_tab[0]});
      check_window("zero_after_reset");

      // Table-driven vectors, including 99->0 and overflow.
      for (int i = 0; i < 11; i++)
         convert(vecs[i].cnt, vecs[i].t, vecs[i].o, $sformatf("vec%0d", i));

      // Randomized values against the model.
      for (int i = 0; i < 20; i++) begin
         do begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(100, 255);
            else                           v = $urandom_range(0, 99);
         end while (v == int'(last_v));
         convert(8'(v), model_tens(v), model_ones(v), $sformatf("rnd%0d", i));
      end

      // 12 -> 34 changed during the conversion at edge N+3.
      convert(8'd12, model_tens(12), model_ones(12), "pre12");
      convert(8'd20, model_tens(20), model_ones(20), "pre20");
      count = 8'd12;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      count = 8'd34;
      wait_conv(7, "mid_first_busy");
      @(negedge clk);
      chk("mid_restart_busy", busy, 1'b1);
      if (an == 2'b10) chk("mid_shows12", seg, model_ones(12));
      else             chk("mid_shows12", seg, model_tens(12));
      wait_conv(9, "mid_second_busy");
      @(negedge clk);
      exp_q.push_back({model_tens(34), model_ones(34)});
      check_window("mid34");
      last_v = 8'd34;

      // Reset asserted at edge N+4 of a conversion.
      count = 8'd77;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_an", an, 2'b10);
      chk("rst_mid_seg", seg, 7'b1000000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_busy", busy, 1'b1);
      chk("rel_an", an, 2'b10);
      chk("rel_seg", seg, 7'b1000000);
      wait_conv(9, "rel_conv_busy");
      @(negedge clk);
      exp_q.push_back({model_tens(77), model_ones(77)});
      check_window("rel77");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
